// File: rtl/bfm_ahbtoapb4_bridge_if.sv
// rtl/bfm_ahbtoapb4_bridge_if.sv - AHB-Lite / APB4 signal bundle for the AHB to APB4 bridge
//
// Purpose: groups the AHB-Lite slave side and the APB4 master side of the
// bridge into one bundle.
//   slave  : the bridge's view (AHB inputs, APB outputs, APB responses in)
//   master : the environment's view (AHB master plus APB slaves)
// Signals:
//   hsel, hwrite, hreadyin, haddr, hwdata, htrans, hsize, hprot : AHB request
//   hrdata, hreadyout, hresp                                    : AHB response
//   psel[NSLOTS], paddr, pwdata, pwrite, penable, pstrb, pprot  : APB request
//   prdata, pready, pslverr                                     : APB response
//   tout                                                        : watchdog pulse
interface bfm_ahbtoapb4_bridge_if #(
  parameter int NSLOTS = 16
);
  logic              hsel;
  logic              hwrite;
  logic              hreadyin;
  logic [31:0]       haddr;
  logic [31:0]       hwdata;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [3:0]        hprot;
  logic [31:0]       hrdata;
  logic              hreadyout;
  logic              hresp;
  logic [NSLOTS-1:0] psel;
  logic [31:0]       paddr;
  logic [31:0]       pwdata;
  logic              pwrite;
  logic              penable;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic              tout;

  modport slave (
    input  hsel, hwrite, hreadyin, haddr, hwdata, htrans, hsize, hprot,
    output hrdata, hreadyout, hresp,
    output psel, paddr, pwdata, pwrite, penable, pstrb, pprot,
    input  prdata, pready, pslverr,
    output tout
  );

  modport master (
    output hsel, hwrite, hreadyin, haddr, hwdata, htrans, hsize, hprot,
    input  hrdata, hreadyout, hresp,
    input  psel, paddr, pwdata, pwrite, penable, pstrb, pprot,
    output prdata, pready, pslverr,
    input  tout
  );
endinterface

// File: rtl/bfm_ahbtoapb4_bridge.sv
// rtl/bfm_ahbtoapb4_bridge.sv - parametrised AHB-Lite to APB4 bridge with decode errors and PREADY watchdog
//
// Purpose: converts single AHB-Lite transfers into APB4 SETUP/ACCESS cycles on
// one of NSLOTS one-hot selects, chosen by haddr[SLOT_LSB+3:SLOT_LSB].
// Out-of-range slots and sizes above a word get a two-cycle AHB ERROR without
// any APB cycle; PSLVERR and a stuck PREADY (TIMEOUT != 0) also end in ERROR.
// Ports:
//   hclk    : clock, all state changes on the rising edge
//   hresetn : asynchronous active-low reset
//   bus     : bfm_ahbtoapb4_bridge_if.slave (AHB request/response, APB
//             request/response, tout watchdog pulse)
// Parameters:
//   TPD      : nominal output delay of the BFM; outputs here are cycle-exact
//   NSLOTS   : number of APB slots (1..16)
//   SLOT_LSB : LSB of the 4-bit slot field in haddr (0..28)
//   TIMEOUT  : ACCESS cycles with PREADY low before abort, 0 disables
module bfm_ahbtoapb4_bridge #(
  parameter int TPD      = 1,
  parameter int NSLOTS   = 16,
  parameter int SLOT_LSB = 24,
  parameter int TIMEOUT  = 0
) (
  input  logic                         hclk,
  input  logic                         hresetn,
  bfm_ahbtoapb4_bridge_if.slave        bus
);

  generate
    if (NSLOTS < 1 || NSLOTS > 16 || SLOT_LSB < 0 || SLOT_LSB > 28 ||
        TIMEOUT < 0 || TPD < 0) begin : g_bad_param
      $error("bfm_ahbtoapb4_bridge: parameter out of range");
    end
  endgenerate

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    ERR1,
    ERR2
  } state_t;

  state_t state, state_nxt;

  // Captured address-phase attributes of the transfer in flight.
  logic [31:0]       addr_q;
  logic              write_q;
  logic [1:0]        size_q;
  logic [1:0]        prot_q;
  logic [3:0]        slot_q;
  logic [31:0]       wdata_q;
  logic [CW-1:0]     wait_q;
  logic              tout_q;

  logic              accept;
  logic              bad_req;
  logic [3:0]        req_slot;
  logic              capture;
  logic              load_wdata;
  logic              wait_inc;
  logic              tout_fire;
  logic [NSLOTS-1:0] psel_dec;
  logic [3:0]        strb;

  // Only NONSEQ/SEQ matters on htrans, and only the data/privileged bits of hprot.
  logic              unused_ok;
  assign unused_ok = &{1'b0, bus.htrans[0], bus.hprot[3:2]};

  assign req_slot = bus.haddr[SLOT_LSB+3:SLOT_LSB];
  assign accept   = bus.hsel & bus.hreadyin & bus.htrans[1];
  assign bad_req  = ({1'b0, req_slot} >= 5'(NSLOTS)) | (bus.hsize > 3'd2);

  assign bus.hrdata = bus.prdata;
  assign bus.tout   = tout_q;

  always_comb begin
    psel_dec = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      psel_dec[i] = (slot_q == 4'(i));
    end
  end

  always_comb begin
    strb = 4'b0000;
    if (write_q) begin
      case (size_q)
        2'd0:    strb = 4'b0001 << addr_q[1:0];
        2'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
        default: strb = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    capture       = 1'b0;
    load_wdata    = 1'b0;
    wait_inc      = 1'b0;
    tout_fire     = 1'b0;
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    bus.psel      = '0;
    bus.penable   = 1'b0;
    bus.pwrite    = 1'b0;
    bus.paddr     = 32'h0;
    bus.pwdata    = 32'h0;
    bus.pstrb     = 4'b0000;
    bus.pprot     = 3'b000;

    case (state)
      IDLE: begin
        if (accept) begin
          capture   = 1'b1;
          state_nxt = bad_req ? ERR1 : SETUP;
        end
      end

      SETUP: begin
        bus.hreadyout = 1'b0;
        bus.psel      = psel_dec;
        bus.pwrite    = write_q;
        bus.paddr     = addr_q;
        // AHB write data arrives in this cycle; pass it through and hold it for ACCESS.
        bus.pwdata    = bus.hwdata;
        bus.pstrb     = strb;
        bus.pprot     = {~prot_q[0], 1'b1, prot_q[1]};
        load_wdata    = 1'b1;
        state_nxt     = ACCESS;
      end

      ACCESS: begin
        bus.hreadyout = bus.pready & ~bus.pslverr;
        bus.psel      = psel_dec;
        bus.penable   = 1'b1;
        bus.pwrite    = write_q;
        bus.paddr     = addr_q;
        bus.pwdata    = wdata_q;
        bus.pstrb     = strb;
        bus.pprot     = {~prot_q[0], 1'b1, prot_q[1]};
        // PREADY is tested first so a response on the last allowed cycle wins over the watchdog.
        if (bus.pready) begin
          if (bus.pslverr) begin
            state_nxt = ERR1;
          end else if (accept) begin
            capture   = 1'b1;
            state_nxt = bad_req ? ERR1 : SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end else if (TIMEOUT != 0) begin
          if (wait_q == CW'(TIMEOUT - 1)) begin
            tout_fire = 1'b1;
            state_nxt = ERR1;
          end else begin
            wait_inc = 1'b1;
          end
        end
      end

      ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b1;
        state_nxt     = ERR2;
      end

      ERR2: begin
        bus.hresp = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      addr_q  <= 32'h0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      prot_q  <= 2'd0;
      slot_q  <= 4'd0;
      wdata_q <= 32'h0;
      wait_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      if (capture) begin
        addr_q  <= bus.haddr;
        write_q <= bus.hwrite;
        size_q  <= bus.hsize[1:0];
        prot_q  <= bus.hprot[1:0];
        slot_q  <= req_slot;
      end
      if (load_wdata) begin
        wdata_q <= bus.hwdata;
      end
      if (state_nxt == SETUP) begin
        wait_q <= '0;
      end else if (wait_inc) begin
        wait_q <= wait_q + CW'(1);
      end
      tout_q <= tout_fire;
    end
  end

endmodule

// File: tb/tb_bfm_ahbtoapb4_bridge.sv
// tb/tb_bfm_ahbtoapb4_bridge.sv - scoreboard testbench for the AHB-Lite to APB4 bridge
module tb_bfm_ahbtoapb4_bridge;

  localparam int NSLOTS   = 4;
  localparam int SLOT_LSB = 24;
  localparam int TIMEOUT  = 8;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;

  always #5 hclk = ~hclk;

  bfm_ahbtoapb4_bridge_if #(.NSLOTS(NSLOTS)) bus ();

  bfm_ahbtoapb4_bridge #(
    .TPD      (1),
    .NSLOTS   (NSLOTS),
    .SLOT_LSB (SLOT_LSB),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  // Single-slave AHB-Lite system: HREADY fed back from the bridge itself.
  assign bus.hreadyin = bus.hreadyout;

  typedef struct {
    logic [NSLOTS-1:0] psel;
    logic [31:0]       paddr;
    logic              pwrite;
    logic [3:0]        pstrb;
    logic [2:0]        pprot;
    logic [31:0]       pwdata;
  } apb_exp_t;

  typedef struct {
    int                low;
    int                pen;
    int                tout;
    int                resp_cyc;
    logic [NSLOTS-1:0] psel;
    logic              resp;
    logic              chk_rd;
    logic [31:0]       rdata;
  } ahb_exp_t;

  apb_exp_t apb_q[$];
  ahb_exp_t ahb_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   slv_wait = 0;
  logic slv_err  = 1'b0;
  int   acc_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] strb_model(input logic [31:0] a, input logic w, input logic [2:0] sz);
    if (!w) return 4'b0000;
    case (sz)
      3'd0:    return 4'b0001 << a[1:0];
      3'd1:    return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_idle();
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
  endtask

  task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [3:0] pr);
    bus.hsel   = 1'b1;
    bus.htrans = 2'b10;
    bus.haddr  = a;
    bus.hwrite = w;
    bus.hsize  = sz;
    bus.hprot  = pr;
  endtask

  // Drive one address phase and push what the APB side and the AHB response should look like.
  task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [3:0] pr,
                       input logic [31:0] wd, input int ws, input logic serr, input logic [31:0] rd);
    apb_exp_t pe;
    ahb_exp_t he;
    logic [3:0] slot;
    logic bad;
    slot = a[SLOT_LSB +: 4];
    bad  = (int'(slot) >= NSLOTS) || (sz > 3'd2);
    he.psel = bad ? '0 : (NSLOTS'(1) << slot);
    he.rdata = rd;
    he.chk_rd = 1'b0;
    if (bad) begin
      he.low = 1; he.pen = 0; he.tout = 0; he.resp = 1'b1; he.resp_cyc = 2;
    end else if (ws >= TIMEOUT) begin
      he.low = TIMEOUT + 2; he.pen = TIMEOUT; he.tout = 1; he.resp = 1'b1; he.resp_cyc = 2;
    end else begin
      he.low = 1 + ws + (serr ? 2 : 0);
      he.pen = ws + 1;
      he.tout = 0;
      he.resp = serr;
      he.resp_cyc = serr ? 2 : 0;
      he.chk_rd = !w && !serr;
      pe.psel   = he.psel;
      pe.paddr  = a;
      pe.pwrite = w;
      pe.pstrb  = strb_model(a, w, sz);
      pe.pprot  = {~pr[0], 1'b1, pr[1]};
      pe.pwdata = wd;
      apb_q.push_back(pe);
    end
    ahb_q.push_back(he);
    slv_wait = ws;
    slv_err  = serr;
    drive_addr(a, w, sz, pr);
  endtask

  // Follow a data phase until HREADYOUT is seen high and compare against the oldest AHB expectation.
  task automatic finish_xfer(input string tag);
    ahb_exp_t e;
    int low = 0;
    int pen = 0;
    int tout = 0;
    int rcyc = 0;
    int cyc = 0;
    logic [NSLOTS-1:0] ps = '0;
    logic done = 1'b0;
    if (ahb_q.size() == 0) begin
      check({tag, "_queue"}, 32'(ahb_q.size()), 32'd1);
      return;
    end
    e = ahb_q.pop_front();
    while (!done && cyc < 40) begin
      @(negedge hclk);
      cyc++;
      if (bus.penable) pen++;
      if (bus.tout) tout++;
      if (bus.hresp) rcyc++;
      ps |= bus.psel;
      if (bus.hreadyout) done = 1'b1;
      else low++;
    end
    if (!done) begin
      check({tag, "_ready_bound"}, 32'(bus.hreadyout), 32'd1);
    end else begin
      check({tag, "_low_cycles"}, 32'(low), 32'(e.low));
      check({tag, "_penable_cycles"}, 32'(pen), 32'(e.pen));
      check({tag, "_tout_pulses"}, 32'(tout), 32'(e.tout));
      check({tag, "_hresp_cycles"}, 32'(rcyc), 32'(e.resp_cyc));
      check({tag, "_psel_seen"}, 32'(ps), 32'(e.psel));
      check({tag, "_hresp"}, 32'(bus.hresp), 32'(e.resp));
      if (e.chk_rd) check({tag, "_hrdata"}, bus.hrdata, e.rdata);
    end
  endtask

  // APB slave: PREADY after slv_wait ACCESS cycles, optional PSLVERR on the ready cycle.
  initial begin
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    forever begin
      @(posedge hclk);
      #1;
      if ((|bus.psel) && bus.penable) begin
        bus.pready  = (acc_cnt >= slv_wait);
        bus.pslverr = bus.pready & slv_err;
        acc_cnt++;
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        acc_cnt     = 0;
      end
    end
  end

  // APB monitor: every completing ACCESS cycle pops one expected APB transfer.
  initial begin
    forever begin
      @(negedge hclk);
      if (hresetn && (|bus.psel) && bus.penable && bus.pready) begin
        if (apb_q.size() == 0) begin
          check("apb_unexpected_psel", 32'(bus.psel), 32'd0);
        end else begin
          apb_exp_t e;
          e = apb_q.pop_front();
          check("apb_psel", 32'(bus.psel), 32'(e.psel));
          check("apb_paddr", bus.paddr, e.paddr);
          check("apb_pwrite", 32'(bus.pwrite), 32'(e.pwrite));
          check("apb_pstrb", 32'(bus.pstrb), 32'(e.pstrb));
          check("apb_pprot", 32'(bus.pprot), 32'(e.pprot));
          if (e.pwrite) check("apb_pwdata", bus.pwdata, e.pwdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive_idle();
    bus.haddr  = 32'h0;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'd0;
    bus.hprot  = 4'd0;
    bus.hwdata = 32'h1234_5678;
    bus.prdata = 32'h0;
    hresetn    = 1'b0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    check("rst_hreadyout", 32'(bus.hreadyout), 32'd1);
    check("rst_hresp", 32'(bus.hresp), 32'd0);
    check("rst_psel", 32'(bus.psel), 32'd0);
    check("rst_penable", 32'(bus.penable), 32'd0);
    check("rst_pwrite", 32'(bus.pwrite), 32'd0);
    check("rst_paddr", bus.paddr, 32'd0);
    check("rst_pwdata", bus.pwdata, 32'd0);
    check("rst_pstrb", 32'(bus.pstrb), 32'd0);
    check("rst_pprot", 32'(bus.pprot), 32'd0);
    check("rst_tout", 32'(bus.tout), 32'd0);
    hresetn = 1'b1;
    step();

    // Zero-wait word write to slot 3.
    issue(32'h0300_0004, 1'b1, 3'd2, 4'b0011, 32'hA5A5_1234, 0, 1'b0, 32'h0);
    step(); bus.hwdata = 32'hA5A5_1234; drive_idle();
    finish_xfer("wr_word"); step();

    // Read with three wait states.
    bus.prdata = 32'hDEAD_BEEF;
    issue(32'h0200_0010, 1'b0, 3'd2, 4'b0000, 32'h0, 3, 1'b0, 32'hDEAD_BEEF);
    step(); bus.hwdata = 32'h0; drive_idle();
    finish_xfer("rd_wait3"); step();

    // Byte write then halfword write, second address phase overlapping the first data phase.
    issue(32'h0100_0003, 1'b1, 3'd0, 4'b0010, 32'hC300_0000, 0, 1'b0, 32'h0);
    step(); bus.hwdata = 32'hC300_0000;
    issue(32'h0100_0002, 1'b1, 3'd1, 4'b0001, 32'hBEEF_0000, 0, 1'b0, 32'h0);
    finish_xfer("b2b_byte");
    step(); bus.hwdata = 32'hBEEF_0000; drive_idle();
    finish_xfer("b2b_half"); step();

    // Slot beyond NSLOTS and oversize transfer: error without APB cycle.
    issue(32'h0500_0000, 1'b1, 3'd2, 4'b0000, 32'h5555_5555, 0, 1'b0, 32'h0);
    step(); drive_idle();
    finish_xfer("slot5_err"); step();
    issue(32'h0000_0000, 1'b0, 3'd3, 4'b0000, 32'h0, 0, 1'b0, 32'h0);
    step(); drive_idle();
    finish_xfer("size3_err"); step();

    // T-1 wait states: PREADY on the last allowed cycle completes normally.
    issue(32'h0000_0100, 1'b1, 3'd2, 4'b0000, 32'h7777_0007, TIMEOUT - 1, 1'b0, 32'h0);
    step(); bus.hwdata = 32'h7777_0007; drive_idle();
    finish_xfer("wait_edge"); step();

    // Slave error, then a normal read.
    issue(32'h0200_0020, 1'b1, 3'd1, 4'b0000, 32'h0000_ABCD, 1, 1'b1, 32'h0);
    step(); bus.hwdata = 32'h0000_ABCD; drive_idle();
    finish_xfer("pslverr"); step();
    bus.prdata = 32'h0BAD_F00D;
    issue(32'h0100_0040, 1'b0, 3'd2, 4'b0010, 32'h0, 0, 1'b0, 32'h0BAD_F00D);
    step(); drive_idle();
    finish_xfer("rd_after_err"); step();

    // PREADY held low: watchdog abort.
    issue(32'h0100_0000, 1'b0, 3'd2, 4'b0000, 32'h0, 1000, 1'b0, 32'h0);
    step(); drive_idle();
    finish_xfer("timeout"); step();

    // Asynchronous reset in the middle of ACCESS.
    slv_wait = 1000;
    slv_err  = 1'b0;
    drive_addr(32'h0100_0008, 1'b1, 3'd2, 4'b0000);
    step(); bus.hwdata = 32'h1111_2222; drive_idle();
    step(); step();
    check("pre_reset_penable", 32'(bus.penable), 32'd1);
    #3;
    hresetn = 1'b0;
    #1;
    check("arst_psel", 32'(bus.psel), 32'd0);
    check("arst_penable", 32'(bus.penable), 32'd0);
    check("arst_hreadyout", 32'(bus.hreadyout), 32'd1);
    check("arst_hresp", 32'(bus.hresp), 32'd0);
    check("arst_pstrb", 32'(bus.pstrb), 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    step();

    // Normal traffic after reset.
    issue(32'h0300_0000, 1'b1, 3'd1, 4'b0001, 32'h0000_5A5A, 0, 1'b0, 32'h0);
    step(); bus.hwdata = 32'h0000_5A5A; drive_idle();
    finish_xfer("post_rst_half"); step();
    bus.prdata = 32'h600D_CAFE;
    issue(32'h0000_0044, 1'b0, 3'd2, 4'b0000, 32'h0, 2, 1'b0, 32'h600D_CAFE);
    step(); drive_idle();
    finish_xfer("post_rst_rd"); step();

    repeat (2) step();
    check("apb_queue_empty", 32'(apb_q.size()), 32'd0);
    check("ahb_queue_empty", 32'(ahb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
